vga_text_engine: RTL and testbench
==================================

Name: vga_text_engine

Overview:
Parametrised text-mode VGA engine: generates sync/blank timing, walks a COLS x ROWS character grid, fetches packed ASCII words from text RAM and glyph rows from font ROM through a fixed 3-tick pipeline, and drives RGB with fg/bg colours and a blinking cursor.
Single clock domain; pixel rate set by the pix_en strobe. Sits between the CPU-visible text memory and the VGA DAC pins, replacing the fixed 640x480/70-column display path.

Parameters:
H_ACTIVE 640, H_FP 16, H_SYNC 96, H_BP 48: horizontal timing in pixels.
V_ACTIVE 480, V_FP 10, V_SYNC 2, V_BP 33: vertical timing in lines.
CHAR_W 9, CHAR_H 16: glyph cell size in pixels.
COLS 70, ROWS 30: text grid; COLS*CHAR_W<=H_ACTIVE, ROWS*CHAR_H<=V_ACTIVE.
BYTES_PER_WORD 4: ASCII bytes per text word; power of two.
ADDR_W 10: text word address width.
BLINK_FRAMES 30: frames per cursor blink half-period.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
pix_en  in  1  pixel strobe; all state advances only when high
text_addr  out  ADDR_W  text RAM word address
text_data  in  8*BYTES_PER_WORD  text word, valid 1 pix_en tick after text_addr
font_addr  out  8+clog2(CHAR_H)  {ascii, glyph_row}
font_row  in  CHAR_W  glyph row bits, valid 1 pix_en tick after font_addr; bit 0 = leftmost pixel
cursor_en  in  1  cursor enable
cursor_col  in  clog2(COLS)  cursor column
cursor_row  in  clog2(ROWS)  cursor row
fg_color  in  24  foreground {R,G,B}
bg_color  in  24  background {R,G,B}
hsync  out  1  active-low
vsync  out  1  active-low
blank_n  out  1  high during active video
vga_r, vga_g, vga_b  out  8 each  pixel colour
frame_start  out  1  one-tick pulse (qualified by pix_en) when h=0,v=0 enters stage 0

Behaviour:
- Reset (sync, active-high, wins over pix_en): hsync=1, vsync=1, blank_n=0, rgb=0, frame_start=0, text_addr=0, font_addr=0; all counters, pipeline valids, blink phase and blink counter 0.
- pix_en low: every register holds; outputs frozen.
- Stage 0 counters: h 0..H_TOTAL-1, v 0..V_TOTAL-1 (TOTAL = sum of four terms); v increments when h wraps; both wrap to 0.
- Cell tracking without divider: x_in_cell 0..CHAR_W-1, col increments on x_in_cell wrap; y_in_cell 0..CHAR_H-1, row increments on wrap; row_base accumulates +COLS per text row, cleared at v wrap; x/col cleared at h wrap.
- in_text = h<COLS*CHAR_W and v<ROWS*CHAR_H; active = h<H_ACTIVE and v<V_ACTIVE.
- Stage 1: idx = row_base+col; text_addr = idx/BYTES_PER_WORD, lane = idx mod BYTES_PER_WORD registered.
- Stage 2: ascii = text_data byte[lane], little-endian (lane 0 = bits 7:0); font_addr = {ascii, y_in_cell}.
- Stage 3: pix = font_row[x_in_cell]; cursor cell (col==cursor_col, row==cursor_row, cursor_en, blink_on) inverts pix; colour = pix ? fg_color : bg_color; outside in_text -> bg_color; outside active -> 0.
- Sync/blank/position delayed alongside data; all video outputs registered. Latency: pixel (h,v) appears at outputs 3 pix_en ticks after entering stage 0.
- hsync low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC); vsync likewise on v.
- cursor_*, fg/bg_color sampled into shadow registers at frame_start; mid-frame changes take effect next frame.
- Blink: counter increments per frame; at BLINK_FRAMES-1 it clears and blink_on toggles.
- Reset mid-frame: restart at h=v=0, pipeline flushed, blank_n low until first valid pixel.

Decomposition:
- Package vga_text_pkg: timing localparams (H_TOTAL, V_TOTAL), clog2 widths, colour typedef (24-bit RGB), default sync polarity.
- Sub-module vga_timing_gen: h/v counters, sync, active, frame_start; engine instantiates it and owns cell tracking, fetch pipeline and cursor.

Test Plan:
- pix_en every 2nd clk, reset 1 clk -> hsync period 800 ticks, low for 96 starting at h=656; vsync period 525 lines, low 2 lines from v=490.
- Text word 0 = 0x44434241, font ROM model -> cells 0..3 issue font_addr ascii 0x41,0x42,0x43,0x44; first pixel at outputs 3 ticks after frame_start.
- h=630..639 in visible line -> rgb = bg_color; h>=640 -> rgb=0, blank_n=0.
- cursor_en=1 at (2,5), BLINK_FRAMES=2 -> cell inverted in frames 2-3, normal in 0-1 and 4-5.
- pix_en held low 50 clks mid-line -> all outputs constant; resume continues at the same h.
- Reset asserted at v=200 -> next tick outputs at reset values; frame_start 1 pix_en tick after release.

Source files
------------

// File: rtl/vga_text_pkg.sv
// Shared definitions for the text-mode VGA engine.
//   - default timing values and the derived line/frame totals
//   - clog2 helper used for counter and port widths (never returns 0)
//   - 24-bit RGB colour type, sync polarity, per-stage control flags
package vga_text_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    // Both syncs are active-low.
    localparam logic SYNC_ACTIVE = 1'b0;

    typedef logic [23:0] rgb_t;

    // Control flags that travel down the fetch pipeline next to the data.
    typedef struct packed {
        logic valid;
        logic hsync;
        logic vsync;
        logic active;
        logic in_text;
    } ctl_t;

    // Bits needed to hold 0..n-1, with a minimum of 1.
    function automatic int clog2(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) r = i + 1;
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// Raster timing for the text engine (stage 0 of the pipeline).
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   i_pix_en          pixel strobe; nothing moves while low
//   o_h, o_v          current pixel position
//   o_run             stage 0 holds a real pixel (low until first tick after reset)
//   o_h_wrap/o_v_wrap position is the last pixel of a line / last line of a frame
//   o_active          position is inside the visible area
//   o_hsync/o_vsync   sync levels for the current position
//   o_frame_start     registered: stage 0 holds (0,0)
//   o_frame_load      strobe: this tick loads (0,0) into stage 0
//   o_frame_wrap      strobe: this tick wraps from the last pixel to (0,0)
module vga_timing_gen
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE = DEF_H_ACTIVE,
    parameter int H_FP     = DEF_H_FP,
    parameter int H_SYNC   = DEF_H_SYNC,
    parameter int H_BP     = DEF_H_BP,
    parameter int V_ACTIVE = DEF_V_ACTIVE,
    parameter int V_FP     = DEF_V_FP,
    parameter int V_SYNC   = DEF_V_SYNC,
    parameter int V_BP     = DEF_V_BP,
    parameter int HW       = clog2(H_ACTIVE + H_FP + H_SYNC + H_BP + 1),
    parameter int VW       = clog2(V_ACTIVE + V_FP + V_SYNC + V_BP + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_pix_en,
    output logic [HW-1:0] o_h,
    output logic [VW-1:0] o_v,
    output logic          o_run,
    output logic          o_h_wrap,
    output logic          o_v_wrap,
    output logic          o_active,
    output logic          o_hsync,
    output logic          o_vsync,
    output logic          o_frame_start,
    output logic          o_frame_load,
    output logic          o_frame_wrap
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS      = HW'(H_ACTIVE);
    localparam logic [VW-1:0] V_VIS      = VW'(V_ACTIVE);
    localparam logic [HW-1:0] HS_START   = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] VS_START   = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [HW-1:0] r_h;
    logic [VW-1:0] r_v;
    logic          r_run;
    logic          r_frame_start;
    logic          w_h_wrap;
    logic          w_v_wrap;

    assign w_h_wrap = (r_h == H_LAST);
    assign w_v_wrap = (r_v == V_LAST);

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values of the others, independent of block order.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_h           <= '0;
            r_v           <= '0;
            r_run         <= 1'b0;
            r_frame_start <= 1'b0;
        end else if (i_pix_en) begin
            if (!r_run) begin
                // First tick after reset: (0,0) enters stage 0 without moving.
                r_run         <= 1'b1;
                r_frame_start <= 1'b1;
            end else begin
                r_frame_start <= w_h_wrap && w_v_wrap;
                if (w_h_wrap) begin
                    r_h <= '0;
                    r_v <= w_v_wrap ? '0 : r_v + 1'b1;
                end else begin
                    r_h <= r_h + 1'b1;
                end
            end
        end
    end

    assign o_h           = r_h;
    assign o_v           = r_v;
    assign o_run         = r_run;
    assign o_h_wrap      = w_h_wrap;
    assign o_v_wrap      = w_v_wrap;
    assign o_active      = (r_h < H_VIS) && (r_v < V_VIS);
    assign o_hsync       = (r_h >= HS_START && r_h < HS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_vsync       = (r_v >= VS_START && r_v < VS_END) ? SYNC_ACTIVE : ~SYNC_ACTIVE;
    assign o_frame_start = r_frame_start;
    assign o_frame_load  = i_pix_en && (!r_run || (w_h_wrap && w_v_wrap));
    assign o_frame_wrap  = i_pix_en && r_run && w_h_wrap && w_v_wrap;

endmodule

// File: rtl/vga_text_engine.sv
// Text-mode VGA engine: walks a COLS x ROWS character grid in step with the
// raster, fetches packed ASCII words and glyph rows through a 3-tick
// pipeline and drives RGB with fg/bg colours and a blinking cursor.
// Ports:
//   clk, reset, pix_en           clock, sync active-high reset, pixel strobe
//   text_addr / text_data        text RAM word address / word (1 tick later)
//   font_addr / font_row         {ascii, glyph_row} / glyph bits (1 tick later, bit 0 leftmost)
//   cursor_en/_col/_row          cursor control, sampled at frame start
//   fg_color, bg_color           colours, sampled at frame start
//   hsync, vsync, blank_n        registered sync (active-low) and blanking
//   vga_r, vga_g, vga_b          registered pixel colour
//   frame_start                  stage 0 holds pixel (0,0)
module vga_text_engine
    import vga_text_pkg::*;
#(
    parameter int H_ACTIVE       = DEF_H_ACTIVE,
    parameter int H_FP           = DEF_H_FP,
    parameter int H_SYNC         = DEF_H_SYNC,
    parameter int H_BP           = DEF_H_BP,
    parameter int V_ACTIVE       = DEF_V_ACTIVE,
    parameter int V_FP           = DEF_V_FP,
    parameter int V_SYNC         = DEF_V_SYNC,
    parameter int V_BP           = DEF_V_BP,
    parameter int CHAR_W         = 9,
    parameter int CHAR_H         = 16,
    parameter int COLS           = 70,
    parameter int ROWS           = 30,
    parameter int BYTES_PER_WORD = 4,
    parameter int ADDR_W         = 10,
    parameter int BLINK_FRAMES   = 30
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        pix_en,
    output logic [ADDR_W-1:0]           text_addr,
    input  logic [8*BYTES_PER_WORD-1:0] text_data,
    output logic [8+clog2(CHAR_H)-1:0]  font_addr,
    input  logic [CHAR_W-1:0]           font_row,
    input  logic                        cursor_en,
    input  logic [clog2(COLS)-1:0]      cursor_col,
    input  logic [clog2(ROWS)-1:0]      cursor_row,
    input  logic [23:0]                 fg_color,
    input  logic [23:0]                 bg_color,
    output logic                        hsync,
    output logic                        vsync,
    output logic                        blank_n,
    output logic [7:0]                  vga_r,
    output logic [7:0]                  vga_g,
    output logic [7:0]                  vga_b,
    output logic                        frame_start
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = clog2(H_TOTAL + 1);
    localparam int VW = clog2(V_TOTAL + 1);
    localparam int XW = clog2(CHAR_W);
    localparam int YW = clog2(CHAR_H);
    // Column/row counters keep running through blanking, so size them for
    // the whole line/frame rather than the text grid.
    localparam int CW = clog2(H_TOTAL / CHAR_W + 1);
    localparam int RW = clog2(V_TOTAL / CHAR_H + 1);
    localparam int LW = clog2(BYTES_PER_WORD);
    localparam int IW = ADDR_W + LW;
    localparam int BW = clog2(BLINK_FRAMES);

    localparam logic [HW-1:0] TEXT_W     = HW'(COLS * CHAR_W);
    localparam logic [VW-1:0] TEXT_H     = VW'(ROWS * CHAR_H);
    localparam logic [XW-1:0] X_LAST     = XW'(CHAR_W - 1);
    localparam logic [YW-1:0] Y_LAST     = YW'(CHAR_H - 1);
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_FRAMES - 1);

    // Stage 0: raster timing.
    logic [HW-1:0] w_h;
    logic [VW-1:0] w_v;
    logic w_run, w_h_wrap, w_v_wrap, w_active, w_hsync0, w_vsync0;
    logic w_frame_load, w_frame_wrap;

    vga_timing_gen #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .HW(HW), .VW(VW)
    ) u_timing (
        .clk          (clk),
        .reset        (reset),
        .i_pix_en     (pix_en),
        .o_h          (w_h),
        .o_v          (w_v),
        .o_run        (w_run),
        .o_h_wrap     (w_h_wrap),
        .o_v_wrap     (w_v_wrap),
        .o_active     (w_active),
        .o_hsync      (w_hsync0),
        .o_vsync      (w_vsync0),
        .o_frame_start(frame_start),
        .o_frame_load (w_frame_load),
        .o_frame_wrap (w_frame_wrap)
    );

    // Stage 0: cell tracking, counted alongside h/v instead of dividing.
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [CW-1:0] r_col;
    logic [RW-1:0] r_row;
    logic [IW-1:0] r_row_base;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_x        <= '0;
            r_y        <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_row_base <= '0;
        end else if (pix_en && w_run) begin
            if (w_h_wrap) begin
                r_x   <= '0;
                r_col <= '0;
                if (w_v_wrap) begin
                    r_y        <= '0;
                    r_row      <= '0;
                    r_row_base <= '0;
                end else if (r_y == Y_LAST) begin
                    r_y        <= '0;
                    r_row      <= r_row + 1'b1;
                    r_row_base <= r_row_base + IW'(COLS);
                end else begin
                    r_y <= r_y + 1'b1;
                end
            end else if (r_x == X_LAST) begin
                r_x   <= '0;
                r_col <= r_col + 1'b1;
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

    ctl_t          w_ctl0;
    logic [IW-1:0] w_idx;

    assign w_ctl0 = '{valid:   w_run,
                      hsync:   w_hsync0,
                      vsync:   w_vsync0,
                      active:  w_active,
                      in_text: (w_h < TEXT_W) && (w_v < TEXT_H)};
    assign w_idx  = r_row_base + IW'(r_col);

    // Frame-stable copies of the CPU-side controls, plus cursor blink phase.
    logic             r_cur_en;
    logic [CW-1:0]    r_cur_col;
    logic [RW-1:0]    r_cur_row;
    rgb_t             r_fg;
    rgb_t             r_bg;
    logic [BW-1:0]    r_blink_cnt;
    logic             r_blink_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cur_en    <= 1'b0;
            r_cur_col   <= '0;
            r_cur_row   <= '0;
            r_fg        <= '0;
            r_bg        <= '0;
            r_blink_cnt <= '0;
            r_blink_on  <= 1'b0;
        end else begin
            if (w_frame_load) begin
                r_cur_en  <= cursor_en;
                r_cur_col <= CW'(cursor_col);
                r_cur_row <= RW'(cursor_row);
                r_fg      <= fg_color;
                r_bg      <= bg_color;
            end
            // Counting on the wrap (not the post-reset load) makes frame 0
            // the first frame of a blink half-period.
            if (w_frame_wrap) begin
                if (r_blink_cnt == BLINK_LAST) begin
                    r_blink_cnt <= '0;
                    r_blink_on  <= ~r_blink_on;
                end else begin
                    r_blink_cnt <= r_blink_cnt + 1'b1;
                end
            end
        end
    end

    // Stage 1: word address and byte lane.  Stage 2: glyph address.
    ctl_t          r_ctl1, r_ctl2;
    logic [XW-1:0] r_x1, r_x2;
    logic [YW-1:0] r_y1;
    logic [CW-1:0] r_col1, r_col2;
    logic [RW-1:0] r_row1, r_row2;
    logic [LW-1:0] r_lane1;
    logic [7:0]    w_ascii;

    assign w_ascii = text_data[{r_lane1, 3'b000} +: 8];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ctl1    <= '0;
            r_ctl2    <= '0;
            r_x1      <= '0;
            r_x2      <= '0;
            r_y1      <= '0;
            r_col1    <= '0;
            r_col2    <= '0;
            r_row1    <= '0;
            r_row2    <= '0;
            r_lane1   <= '0;
            text_addr <= '0;
            font_addr <= '0;
        end else if (pix_en) begin
            r_ctl1    <= w_ctl0;
            r_x1      <= r_x;
            r_y1      <= r_y;
            r_col1    <= r_col;
            r_row1    <= r_row;
            text_addr <= w_idx[IW-1:LW];
            r_lane1   <= w_idx[LW-1:0];

            r_ctl2    <= r_ctl1;
            r_x2      <= r_x1;
            r_col2    <= r_col1;
            r_row2    <= r_row1;
            font_addr <= {w_ascii, r_y1};
        end
    end

    // Stage 3: pixel, cursor inversion and colour.
    logic w_pix;
    logic w_cursor_hit;
    rgb_t w_rgb;

    assign w_pix        = font_row[r_x2];
    assign w_cursor_hit = r_cur_en && r_blink_on &&
                          (r_col2 == r_cur_col) && (r_row2 == r_cur_row);

    // NOTE: a default on the first line keeps every path assigned, so this
    // stays combinational instead of inferring a latch.
    always_comb begin
        w_rgb = '0;
        if (r_ctl2.active) begin
            w_rgb = r_bg;
            if (r_ctl2.in_text && (w_pix ^ w_cursor_hit)) w_rgb = r_fg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hsync   <= ~SYNC_ACTIVE;
            vsync   <= ~SYNC_ACTIVE;
            blank_n <= 1'b0;
            {vga_r, vga_g, vga_b} <= '0;
        end else if (pix_en) begin
            if (r_ctl2.valid) begin
                hsync   <= r_ctl2.hsync;
                vsync   <= r_ctl2.vsync;
                blank_n <= r_ctl2.active;
                {vga_r, vga_g, vga_b} <= w_rgb;
            end else begin
                hsync   <= ~SYNC_ACTIVE;
                vsync   <= ~SYNC_ACTIVE;
                blank_n <= 1'b0;
                {vga_r, vga_g, vga_b} <= '0;
            end
        end
    end

endmodule

// File: tb/tb_vga_text_engine.sv
// Directed bench for vga_text_engine on a reduced raster:
// 56 x 30 total (40 x 24 visible), 9x4 cells, 4 x 6 grid, blink every 2 frames.
// The tick counter tk counts pix_en edges since the last reset release;
// pixel k (raster order) enters stage 0 at tick k+1 and reaches the pins at k+4.
module tb_vga_text_engine;

    localparam int H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 6;
    localparam int V_ACTIVE = 24, V_FP = 2, V_SYNC = 2, V_BP = 2;
    localparam int CHAR_W = 9, CHAR_H = 4, COLS = 4, ROWS = 6;
    localparam int BPW = 4, ADDR_W = 10, BLINK_FRAMES = 2;

    localparam logic [31:0] FG0 = 32'hFFEE11;
    localparam logic [31:0] FG1 = 32'h00FF00;
    localparam logic [31:0] BG  = 32'h102030;

    logic              clk = 1'b0;
    logic              reset;
    logic              pix_en;
    logic              pix_hold;
    logic [ADDR_W-1:0] text_addr;
    logic [31:0]       text_data;
    logic [9:0]        font_addr;
    logic [8:0]        font_row;
    logic              cursor_en;
    logic [1:0]        cursor_col;
    logic [2:0]        cursor_row;
    logic [23:0]       fg_color, bg_color;
    logic              hsync, vsync, blank_n, frame_start;
    logic [7:0]        vga_r, vga_g, vga_b;

    logic [31:0] text_mem [0:(1<<ADDR_W)-1];

    int n_checks = 0;
    int n_errors = 0;
    int tk = 0;

    always #5 clk = ~clk;

    // Memories answer within the tick, so data is ready at the next pix_en edge.
    assign text_data = text_mem[text_addr];
    // Glyph model: row bits = {1, ascii} xor glyph_row.
    assign font_row  = {1'b1, font_addr[9:2]} ^ {7'b0, font_addr[1:0]};

    vga_text_engine #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CHAR_W(CHAR_W), .CHAR_H(CHAR_H), .COLS(COLS), .ROWS(ROWS),
        .BYTES_PER_WORD(BPW), .ADDR_W(ADDR_W), .BLINK_FRAMES(BLINK_FRAMES)
    ) dut (
        .clk(clk), .reset(reset), .pix_en(pix_en),
        .text_addr(text_addr), .text_data(text_data),
        .font_addr(font_addr), .font_row(font_row),
        .cursor_en(cursor_en), .cursor_col(cursor_col), .cursor_row(cursor_row),
        .fg_color(fg_color), .bg_color(bg_color),
        .hsync(hsync), .vsync(vsync), .blank_n(blank_n),
        .vga_r(vga_r), .vga_g(vga_g), .vga_b(vga_b),
        .frame_start(frame_start)
    );

    // pix_en toggles on falling edges: high on every 2nd rising edge.
    initial begin
        pix_en = 1'b0;
        forever begin
            @(negedge clk);
            if (pix_hold) pix_en = 1'b0;
            else          pix_en = ~pix_en;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (tick %0d)", tag, obs, exp, tk);
        end
    endtask

    // Advance to the next rising edge with pix_en high, then sample 1 unit later.
    task automatic pix_tick();
        bit got;
        got = 1'b0;
        for (int i = 0; i < 8 && !got; i++) begin
            @(posedge clk);
            if (pix_en) got = 1'b1;
        end
        if (!got) begin
            n_checks++;
            n_errors++;
            $error("FAIL pix_tick: observed no pix_en edge expected one within 8 clocks");
        end
        #1;
        tk++;
    endtask

    task automatic goto(input int n);
        while (tk < n) pix_tick();
    endtask

    function automatic logic [31:0] rgb();
        return {8'h00, vga_r, vga_g, vga_b};
    endfunction

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) text_mem[i] = 32'h0;
        text_mem[0] = 32'h44434241;
        text_mem[1] = 32'h48474645;
        pix_hold   = 1'b0;
        reset      = 1'b1;
        cursor_en  = 1'b1;
        cursor_col = 2'd2;
        cursor_row = 3'd5;
        fg_color   = FG0[23:0];
        bg_color   = BG[23:0];

        repeat (3) @(posedge clk);
        #1;
        check("rst_hsync", hsync, 1);
        check("rst_vsync", vsync, 1);
        check("rst_blank", blank_n, 0);
        check("rst_rgb", rgb(), 0);
        check("rst_fs", frame_start, 0);
        check("rst_text_addr", text_addr, 0);
        check("rst_font_addr", font_addr, 0);
        reset = 1'b0;
        tk = 0;

        // First frame, first line: fetch order and first pixels.
        goto(1);  check("fs_first", frame_start, 1);
                  check("blank_t1", blank_n, 0);
        goto(2);  check("fs_drop", frame_start, 0);
                  check("text_addr_c0", text_addr, 0);
        goto(3);  check("font_c0", font_addr, 32'h104);
                  check("blank_t3", blank_n, 0);
        goto(4);  check("px00_rgb", rgb(), FG0);
                  check("px00_blank", blank_n, 1);
                  check("px00_hsync", hsync, 1);
        goto(5);  check("px10_rgb", rgb(), BG);
        goto(12); check("font_c1", font_addr, 32'h108);
                  check("px80_rgb", rgb(), FG0);
        goto(21); check("font_c2", font_addr, 32'h10C);
        goto(30); check("font_c3", font_addr, 32'h110);

        // Right margin of the text grid, then horizontal blanking.
        goto(40); check("h36_rgb", rgb(), BG);
                  check("h36_blank", blank_n, 1);
        goto(43); check("h39_rgb", rgb(), BG);
        goto(44); check("h40_rgb", rgb(), 0);
                  check("h40_blank", blank_n, 0);

        // hsync low for h in [44,50), period 56.
        goto(47);  check("hs_h43", hsync, 1);
        goto(48);  check("hs_h44", hsync, 0);
        goto(53);  check("hs_h49", hsync, 0);
        goto(54);  check("hs_h50", hsync, 1);
        goto(103); check("hs_l1_h43", hsync, 1);
        goto(104); check("hs_l1_h44", hsync, 0);

        // Mid-frame colour change must wait for the next frame.
        goto(200);
        fg_color = FG1[23:0];

        // Pixel (0,4): char 0x45 from word 1 lane 0.
        goto(228); check("px04_rgb", rgb(), FG0);
                   check("px04_font", font_addr, 32'h114);
                   check("px04_text_addr", text_addr, 1);

        // Freeze pix_en for 50 clocks; everything must hold.
        pix_hold = 1'b1;
        repeat (50) @(posedge clk);
        #1;
        check("hold_rgb", rgb(), FG0);
        check("hold_blank", blank_n, 1);
        check("hold_hsync", hsync, 1);
        check("hold_fs", frame_start, 0);
        check("hold_font", font_addr, 32'h114);
        check("hold_text_addr", text_addr, 1);
        pix_hold = 1'b0;
        goto(229); check("resume_px14_rgb", rgb(), BG);

        // Row 1, col 1: word 1 lane 1 = 0x46, glyph rows 0 and 1.
        goto(234); check("r1c1_text_addr", text_addr, 1);
        goto(236); check("r1c1_font_y0", font_addr, 32'h118);
        goto(292); check("r1c1_font_y1", font_addr, 32'h119);

        // Cursor cell (col 2,row 5), pixel (18,20): frame 0 not inverted.
        goto(1142); check("cur_f0", rgb(), BG);

        // vsync low for v in [26,28).
        goto(1459); check("vs_v25", vsync, 1);
        goto(1460); check("vs_v26", vsync, 0);
        goto(1571); check("vs_v27", vsync, 0);
        goto(1572); check("vs_v28", vsync, 1);

        // Frame boundary.
        goto(1680); check("fs_f1_before", frame_start, 0);
        goto(1681); check("fs_f1", frame_start, 1);
        goto(1682); check("fs_f1_after", frame_start, 0);

        goto(1908); check("px04_f1_newfg", rgb(), FG1);
        goto(2822); check("cur_f1", rgb(), BG);
        goto(4502); check("cur_f2_x0", rgb(), FG1);
        goto(4510); check("cur_f2_x8", rgb(), BG);
        goto(4511); check("cur_f2_neighbour", rgb(), BG);
        goto(6182); check("cur_f3", rgb(), FG1);
        goto(7862); check("cur_f4", rgb(), BG);

        // Reset in the middle of a frame.
        goto(8000);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mrst_hsync", hsync, 1);
        check("mrst_vsync", vsync, 1);
        check("mrst_blank", blank_n, 0);
        check("mrst_rgb", rgb(), 0);
        check("mrst_fs", frame_start, 0);
        check("mrst_text_addr", text_addr, 0);
        check("mrst_font_addr", font_addr, 0);
        reset = 1'b0;
        tk = 0;
        goto(1); check("mrst_fs_t1", frame_start, 1);
        goto(3); check("mrst_blank_t3", blank_n, 0);
        goto(4); check("mrst_px00_blank", blank_n, 1);
                 check("mrst_px00_rgb", rgb(), FG1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
